mux_sel_pipe: RTL

Registered, parametrised N-channel, W-bit channel selector with valid/ready flow control, the pipelined successor to the combinational single-bit 4:1 select used in the DCT datapath. It picks one of NCH coefficient/pixel streams, either under external `sel` control or by autonomous round-robin scan, and presents the chosen word on a one-deep registered output with backpressure. It sits between the row/column DCT stages and the shared downstream quantiser input.

---
 rtl/mux_sel_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered NCH-channel, WIDTH-bit channel selector with
// valid/ready flow control. Picks one input stream either from the manual
// `sel` code (reversed mapping, sel 0 -> highest channel) or by a
// round-robin scan pointer. The chosen word goes to a one-deep output
// register that accepts backpressure.
//
// Optional build macro: MUX_SEL_PIPE_CNT_EN
//   defined   -> adds 16-bit output xfer_cnt counting accepted transfers
//                (wraps 65535 -> 0)
//   undefined -> no counter, no port; everything else is identical
module mux_sel_pipe #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
`ifdef MUX_SEL_PIPE_CNT_EN
  ,
  output logic [15:0]          xfer_cnt
`endif
);

  // Highest channel index, one bit wider than sel so the range test and
  // the reversed mapping never overflow.
  localparam logic [SELW:0]   LAST_W = (SELW+1)'(NCH-1);
  localparam logic [SELW-1:0] LAST   = SELW'(NCH-1);

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             sel_ok;
  logic [SELW-1:0]  man_ch;
  logic [SELW-1:0]  cur_ch;
  logic             cur_ok;
  logic [NCH-1:0]   cur_onehot;
  logic [WIDTH-1:0] cur_data;
  logic             ptr_in_valid;
  logic             free;
  logic             accept;

  // Channel choice: manual code is reversed, scan uses the pointer directly.
  // An out-of-range manual code selects nothing.
  always_comb begin
    sel_ok = ({1'b0, sel} <= LAST_W);
    man_ch = SELW'(LAST_W - {1'b0, sel});
    cur_ch = mode ? ptr_q : man_ch;
    cur_ok = mode | sel_ok;
  end

  // Decode the chosen channel and mux its data; also look up the valid of
  // the channel the scan pointer is parked on.
  always_comb begin
    cur_onehot   = '0;
    cur_data     = '0;
    ptr_in_valid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (cur_ok && (cur_ch == SELW'(c))) begin
        cur_onehot[c] = 1'b1;
        cur_data      = in_data[c*WIDTH +: WIDTH];
      end
      if (ptr_q == SELW'(c)) begin
        ptr_in_valid = in_valid[c];
      end
    end
  end

  // Handshake: only the chosen channel sees ready, and only when the output
  // slot is empty or draining this cycle. Ready is forced low in reset.
  always_comb begin
    free     = !out_valid_q || out_ready;
    in_ready = (rst || !free) ? '0 : cur_onehot;
    accept   = |(in_ready & in_valid);
  end

  // Output slot next state: accept overwrites (no bubble on drain+accept),
  // drain clears valid but keeps data/channel, stall holds everything.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = cur_data;
      out_ch_d    = cur_ch;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Scan pointer: moves past an idle channel or after a transfer, keeps its
  // turn while its channel is stalled. Wraps at NCH-1, frozen in manual mode.
  always_comb begin
    ptr_d = ptr_q;
    if (mode && (accept || !ptr_in_valid)) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + SELW'(1);
    end
  end

  // Output slot and scan pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef MUX_SEL_PIPE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Accepted-transfer counter, free-running modulo 2^16.
  always_comb begin
    cnt_d = accept ? cnt_q + 16'd1 : cnt_q;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
